rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- After reset, sequences a clear sweep that zeroes r1..r31. It then shares the write port between two requesters:
  - Port A: core write-back, single-cycle, stallable. A has priority.
  - Port B: multi-cycle unit, valid/ready handshake.
- A bounded starvation guard ensures B is always eventually granted.
- Sits between the core/multi-cycle unit and the register file write inputs (we, write_reg, write_data).

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- NUM_REGS, 32, register count; the sweep covers 1..NUM_REGS-1
- STARVE_LIMIT, 4, consecutive B losses before B is forced; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_we  in  1  core write-back request
- a_waddr  in  ADDR_W  core destination register
- a_wdata  in  DATA_W  core write data
- a_stall  out  1  core must hold a_we/a_waddr/a_wdata stable; the request is not consumed this cycle
- b_valid  in  1  multi-cycle unit request
- b_waddr  in  ADDR_W  B destination register
- b_wdata  in  DATA_W  B write data
- b_ready  out  1  B request accepted this cycle; transfer = b_valid & b_ready
- rf_we  out  1  register file write enable
- rf_waddr  out  ADDR_W  register file write address
- rf_wdata  out  DATA_W  register file write data
- init_done  out  1  high once the clear sweep has completed
- starve_evt  out  1  one-cycle pulse when a forced B grant occurs

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low. All flops clear immediately on rst_n low.
- Registered state: `state` (INIT, RUN, FORCE_B), `sweep_cnt` [ADDR_W], `wait_cnt` [4].
- All outputs are combinational from the registered state and the current inputs.
- Reset values: state=INIT, sweep_cnt=1, wait_cnt=0. Hence, during reset:
  - rf_we=1, rf_waddr=1, rf_wdata=0 (harmless repeated clear of r1)
  - a_stall=1, b_ready=0, init_done=0, starve_evt=0
- INIT:
  - Outputs: rf_we=1, rf_waddr=sweep_cnt, rf_wdata=0, a_stall=1, b_ready=0.
  - sweep_cnt increments each cycle.
  - When sweep_cnt==NUM_REGS-1, go to RUN the next cycle. The sweep is NUM_REGS-1 = 31 cycles after reset release.
  - a_we and b_valid are ignored; requesters hold their requests.
- RUN arbitration (per cycle):
  - `a_eff` = a_we & (a_waddr!=0). A write to r0 is consumed with no stall and no RF write.
  - a_eff=1: rf_* driven from A, a_stall=0, b_ready=0.
    - If b_valid, wait_cnt increments.
    - If b_valid and wait_cnt==STARVE_LIMIT-1, go to FORCE_B the next cycle.
  - a_eff=0 and b_valid=1: b_ready=1, rf_we=(b_waddr!=0), rf_* driven from B, wait_cnt cleared.
  - Neither: rf_we=0, rf_waddr=0, rf_wdata=0.
  - b_valid=0: wait_cnt cleared.
- FORCE_B (exactly one cycle):
  - a_stall=1, starve_evt=1.
  - If b_valid: b_ready=1 and B writes (r0 suppressed).
  - If b_valid has dropped: no write.
  - wait_cnt cleared; return to RUN.
- init_done = (state!=INIT).
- Write ordering:
  - Writes commit on the RF clock edge in grant order.
  - A and B targeting the same register in different cycles: the later grant wins.
  - No same-cycle collision is possible.
- Reset mid-operation (any state): immediate return to INIT. The sweep restarts from r1 and any pending B request must be re-presented.
- Starvation bound: B is granted at most STARVE_LIMIT+1 cycles after b_valid rises, counting from the end of INIT.

Decomposition:
- Shared package `rf_pkg`:
  - ADDR_W, DATA_W, NUM_REGS
  - state enum rf_arb_state_t {INIT, RUN, FORCE_B}
  - constant REG_ZERO = 0
- No sub-module is needed. The sweep counter and starvation counter are inline; the write mux is one always block.

Test Plan:
1. Reset release, no requests: rf_we=1 with rf_waddr stepping 1..31, rf_wdata=0. init_done rises in cycle 32 and a_stall falls in the same cycle. Post-sweep: all RF registers read 0.
2. RUN: a_we=1, a_waddr=5, a_wdata=0xDEADBEEF, b_valid=0 -> same cycle: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, a_stall=0.
3. a_we=1 (r7) and b_valid=1 (r9, 0x1234) every cycle, STARVE_LIMIT=4 -> A wins for 4 cycles. Cycle 5: a_stall=1, b_ready=1, rf_waddr=9, rf_wdata=0x1234, starve_evt=1. Cycle 6: A resumes.
4. a_we=1 with a_waddr=0 and b_valid=1 (r3, 0x55) -> a_stall=0, b_ready=1, rf_we=1, rf_waddr=3.
5. b_valid=1 with b_waddr=0, A idle -> b_ready=1, rf_we=0. Register 0 stays 0.
6. rst_n pulsed low during FORCE_B -> outputs immediately return to reset values and the sweep restarts at r1. The B request is not acknowledged until after the sweep completes.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        FORCE_B = 2'd2
    } rf_arb_state_t;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rf_write_arbiter.sv
// Owns the register file write port: clears r1..r31 after reset, then arbitrates
// core write-back (A, priority) against a multi-cycle unit (B) with a starvation guard.
//
// Handshakes: A is consumed in any cycle where a_stall is low; B transfers in a
// cycle where b_valid & b_ready are both high, and b_ready never depends on
// anything but registered state and the current request inputs.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W       = rf_pkg::DATA_W,
    parameter int ADDR_W       = rf_pkg::ADDR_W,
    parameter int NUM_REGS     = rf_pkg::NUM_REGS,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_stall,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done,
    output logic              starve_evt
);

    localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic [3:0]        WAIT_LAST  = 4'(STARVE_LIMIT - 1);

    rf_arb_state_t     state;
    logic [ADDR_W-1:0] sweep_cnt;
    logic [3:0]        wait_cnt;
    logic              a_eff;

    assign a_eff = a_we && (a_waddr != REG_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            sweep_cnt <= ADDR_W'(1);
            wait_cnt  <= 4'd0;
        end else begin
            case (state)
                INIT: begin
                    sweep_cnt <= sweep_cnt + ADDR_W'(1);
                    wait_cnt  <= 4'd0;
                    if (sweep_cnt == SWEEP_LAST) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // B only accumulates losses while it is actually waiting behind A.
                    if (a_eff && b_valid) begin
                        wait_cnt <= wait_cnt + 4'd1;
                        if (wait_cnt == WAIT_LAST) begin
                            state <= FORCE_B;
                        end
                    end else begin
                        wait_cnt <= 4'd0;
                    end
                end
                FORCE_B: begin
                    wait_cnt <= 4'd0;
                    state    <= RUN;
                end
                default: begin
                    state    <= INIT;
                    wait_cnt <= 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        rf_we      = 1'b0;
        rf_waddr   = REG_ZERO;
        rf_wdata   = '0;
        a_stall    = 1'b1;
        b_ready    = 1'b0;
        starve_evt = 1'b0;
        case (state)
            INIT: begin
                rf_we    = 1'b1;
                rf_waddr = sweep_cnt;
            end
            RUN: begin
                a_stall = 1'b0;
                if (a_eff) begin
                    rf_we    = 1'b1;
                    rf_waddr = a_waddr;
                    rf_wdata = a_wdata;
                end else if (b_valid) begin
                    b_ready  = 1'b1;
                    rf_we    = (b_waddr != REG_ZERO);
                    rf_waddr = b_waddr;
                    rf_wdata = b_wdata;
                end
            end
            FORCE_B: begin
                starve_evt = 1'b1;
                if (b_valid) begin
                    b_ready  = 1'b1;
                    rf_we    = (b_waddr != REG_ZERO);
                    rf_waddr = b_waddr;
                    rf_wdata = b_wdata;
                end
            end
            default: begin
                rf_we = 1'b0;
            end
        endcase
    end

    assign init_done = (state != INIT);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a register file model fed by the rf_* outputs.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        a_stall;
    logic        b_valid;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        b_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        init_done;
    logic        starve_evt;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf_model [32];
    logic        model_init = 1'b0;
    logic [41:0] obs;

    // Observed outputs: {rf_we, rf_waddr, rf_wdata, a_stall, b_ready, init_done, starve_evt}
    assign obs = {rf_we, rf_waddr, rf_wdata, a_stall, b_ready, init_done, starve_evt};

    always #5 clk = ~clk;

    rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_we       (a_we),
        .a_waddr    (a_waddr),
        .a_wdata    (a_wdata),
        .a_stall    (a_stall),
        .b_valid    (b_valid),
        .b_waddr    (b_waddr),
        .b_wdata    (b_wdata),
        .b_ready    (b_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .init_done  (init_done),
        .starve_evt (starve_evt)
    );

    // Register file model; starts with nonzero junk so the sweep has to clear it.
    always @(posedge clk) begin
        if (!model_init) begin
            for (int i = 0; i < 32; i++) begin
                rf_model[i] <= (i == 0) ? 32'h0 : (32'hA5A5_0000 | 32'(i));
            end
            model_init <= 1'b1;
        end else if (rf_we) begin
            rf_model[rf_waddr] <= rf_wdata;
        end
    end

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs !== {1'b1, 5'd1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", c, obs,
                         {1'b1, 5'd1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_sweep();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 1; k <= 31; k++) begin
            checks++;
            if (obs !== {1'b1, 5'(k), 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL sweep k=%0d got=%h exp=%h", k, obs,
                         {1'b1, 5'(k), 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (obs !== {1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sweep_done got=%h exp=%h", obs, {1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        for (int r = 0; r < 32; r++) begin
            checks++;
            if (rf_model[r] !== 32'h0) begin
                errors++;
                $display("FAIL sweep_clear r%0d got=%h exp=0", r, rf_model[r]);
            end
        end
    endtask

    task automatic test_a_write();
        a_we = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (obs !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL a_write got=%h exp=%h", obs, {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        @(negedge clk);
        a_we = 1'b0;
        #1;
        checks++;
        if (rf_model[5] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL a_write_commit got=%h exp=deadbeef", rf_model[5]);
        end
        checks++;
        if (obs !== {1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL idle got=%h exp=%h", obs, {1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_starvation();
        @(negedge clk);
        a_we = 1'b1; a_waddr = 5'd7; a_wdata = 32'h77;
        b_valid = 1'b1; b_waddr = 5'd9; b_wdata = 32'h1234;
        #1;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (obs !== {1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL starve_a_wins cyc=%0d got=%h exp=%h", c, obs,
                         {1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0});
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (obs !== {1'b1, 5'd9, 32'h1234, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL starve_force_b got=%h exp=%h", obs, {1'b1, 5'd9, 32'h1234, 1'b1, 1'b1, 1'b1, 1'b1});
        end
        @(negedge clk);
        b_valid = 1'b0;
        #1;
        checks++;
        if (obs !== {1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL starve_a_resumes got=%h exp=%h", obs, {1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        @(negedge clk);
        a_we = 1'b0;
        #1;
        checks++;
        if (rf_model[9] !== 32'h1234) begin
            errors++;
            $display("FAIL starve_b_commit got=%h exp=1234", rf_model[9]);
        end
    endtask

    task automatic test_a_r0();
        @(negedge clk);
        a_we = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFF_FFFF;
        b_valid = 1'b1; b_waddr = 5'd3; b_wdata = 32'h55;
        #1;
        checks++;
        if (obs !== {1'b1, 5'd3, 32'h55, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL a_r0_b_wins got=%h exp=%h", obs, {1'b1, 5'd3, 32'h55, 1'b0, 1'b1, 1'b1, 1'b0});
        end
        @(negedge clk);
        a_we = 1'b0; b_valid = 1'b0;
        #1;
        checks++;
        if (rf_model[3] !== 32'h55 || rf_model[0] !== 32'h0) begin
            errors++;
            $display("FAIL a_r0_commit r3=%h r0=%h exp r3=55 r0=0", rf_model[3], rf_model[0]);
        end
    endtask

    task automatic test_b_r0();
        @(negedge clk);
        b_valid = 1'b1; b_waddr = 5'd0; b_wdata = 32'h66;
        #1;
        checks++;
        if (obs !== {1'b0, 5'd0, 32'h66, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b_r0 got=%h exp=%h", obs, {1'b0, 5'd0, 32'h66, 1'b0, 1'b1, 1'b1, 1'b0});
        end
        @(negedge clk);
        b_valid = 1'b0;
        #1;
        checks++;
        if (rf_model[0] !== 32'h0) begin
            errors++;
            $display("FAIL b_r0_commit got=%h exp=0", rf_model[0]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        b_valid = 1'b1; b_waddr = 5'd10; b_wdata = 32'hB;
        #1;
        checks++;
        if (obs !== {1'b1, 5'd10, 32'hB, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_b got=%h exp=%h", obs, {1'b1, 5'd10, 32'hB, 1'b0, 1'b1, 1'b1, 1'b0});
        end
        @(negedge clk);
        b_valid = 1'b0;
        a_we = 1'b1; a_waddr = 5'd10; a_wdata = 32'hA;
        #1;
        checks++;
        if (obs !== {1'b1, 5'd10, 32'hA, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_a got=%h exp=%h", obs, {1'b1, 5'd10, 32'hA, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        @(negedge clk);
        a_we = 1'b0;
        #1;
        checks++;
        if (rf_model[10] !== 32'hA) begin
            errors++;
            $display("FAIL b2b_later_wins got=%h exp=a", rf_model[10]);
        end
    endtask

    task automatic test_reset_in_force_b();
        @(negedge clk);
        a_we = 1'b1; a_waddr = 5'd7; a_wdata = 32'h77;
        b_valid = 1'b1; b_waddr = 5'd9; b_wdata = 32'h1234;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (obs !== {1'b1, 5'd9, 32'h1234, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL rst_pre_force_b got=%h exp=%h", obs, {1'b1, 5'd9, 32'h1234, 1'b1, 1'b1, 1'b1, 1'b1});
        end
        rst_n = 1'b0;
        a_we = 1'b0;
        #1;
        checks++;
        if (obs !== {1'b1, 5'd1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_async got=%h exp=%h", obs, {1'b1, 5'd1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 1; k <= 31; k++) begin
            checks++;
            if (obs !== {1'b1, 5'(k), 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL rst_resweep k=%0d got=%h exp=%h", k, obs,
                         {1'b1, 5'(k), 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (obs !== {1'b1, 5'd9, 32'h1234, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rst_b_after_sweep got=%h exp=%h", obs, {1'b1, 5'd9, 32'h1234, 1'b0, 1'b1, 1'b1, 1'b0});
        end
        checks++;
        if (rf_model[7] !== 32'h0 || rf_model[9] !== 32'h0) begin
            errors++;
            $display("FAIL rst_resweep_clear r7=%h r9=%h exp 0", rf_model[7], rf_model[9]);
        end
        @(negedge clk);
        b_valid = 1'b0;
        #1;
        checks++;
        if (rf_model[9] !== 32'h1234) begin
            errors++;
            $display("FAIL rst_b_commit got=%h exp=1234", rf_model[9]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_we = 1'b0; a_waddr = '0; a_wdata = '0;
        b_valid = 1'b0; b_waddr = '0; b_wdata = '0;
        test_reset();
        test_sweep();
        test_a_write();
        test_starvation();
        test_a_r0();
        test_b_r0();
        test_back_to_back();
        test_reset_in_force_b();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
